// File: rtl/memory_access.sv
// Load/store stage: one LDR/STR/LDRB/STRB per handshake, byte stores via read-modify-write.
// Optional MEMORY_ACCESS_BOUNDS_CHECK_EN aborts word indices >= MEM_WORDS without a bus beat.
module memory_access #(
  parameter int          MEM_WORDS = 8192,
  parameter logic [1:0]  PROT_DATA = 2'b01
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_load,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_dest,
  output logic        wb_valid,
  output logic        wb_write,
  output logic [3:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        wb_abort,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_abort,
  output logic        mem_write,
  output logic        mem_size,
  output logic [1:0]  mem_prot,
  output logic [1:0]  mem_trans
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] READ  = 3'd1;
  localparam logic [2:0] RDATA = 3'd2;
  localparam logic [2:0] WRITE = 3'd3;
  localparam logic [2:0] RESP  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic        load_q, load_d;
  logic        byte_q, byte_d;
  logic [1:0]  lane_q, lane_d;
  logic [7:0]  bdata_q, bdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_write_q, wb_write_d;
  logic        wb_abort_q, wb_abort_d;
  logic [3:0]  wb_dest_q, wb_dest_d;
  logic [31:0] wb_data_q, wb_data_d;

  logic [29:0] word_idx;
  logic [31:0] idx_mapped;
  logic        oob;
  logic [4:0]  shamt;
  logic [63:0] rot_w;
  logic [31:0] load_val;
  logic [31:0] merged;

  assign word_idx = req_addr[31:2];

`ifdef MEMORY_ACCESS_BOUNDS_CHECK_EN
  assign idx_mapped = {2'b00, word_idx};
  assign oob        = idx_mapped >= 32'(MEM_WORDS);
`else
  // Out-of-range indices wrap onto the physical memory.
  assign idx_mapped = {2'b00, word_idx & 30'(MEM_WORDS - 1)};
  assign oob        = 1'b0;
`endif

  always_comb begin
    shamt    = {lane_q, 3'b000};
    rot_w    = {mem_rdata, mem_rdata} >> shamt;
    load_val = byte_q ? {24'h0, rot_w[7:0]} : rot_w[31:0];
    merged   = mem_rdata;
    case (lane_q)
      2'd0:    merged = {mem_rdata[31:8], bdata_q};
      2'd1:    merged = {mem_rdata[31:16], bdata_q, mem_rdata[7:0]};
      2'd2:    merged = {mem_rdata[31:24], bdata_q, mem_rdata[15:0]};
      default: merged = {bdata_q, mem_rdata[23:0]};
    endcase
  end

  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    byte_d      = byte_q;
    lane_d      = lane_q;
    bdata_d     = bdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wb_valid_d  = 1'b0;
    wb_write_d  = 1'b0;
    wb_abort_d  = 1'b0;
    wb_data_d   = 32'h0;
    wb_dest_d   = wb_dest_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          load_d  = req_load;
          byte_d  = req_byte;
          lane_d  = req_addr[1:0];
          bdata_d = req_wdata[7:0];
          if (oob) begin
            state_d    = RESP;
            wb_valid_d = 1'b1;
            wb_abort_d = 1'b1;
            wb_dest_d  = req_dest;
          end else begin
            mem_addr_d = idx_mapped;
            wb_dest_d  = req_dest;
            if (req_load || req_byte) begin
              state_d = READ;
            end else begin
              state_d     = WRITE;
              mem_wdata_d = req_wdata;
            end
          end
        end
      end
      READ: state_d = RDATA;
      RDATA: begin
        if (mem_abort) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_abort_d = 1'b1;
        end else if (load_q) begin
          state_d    = RESP;
          wb_valid_d = 1'b1;
          wb_write_d = 1'b1;
          wb_data_d  = load_val;
        end else begin
          state_d     = WRITE;
          mem_wdata_d = merged;
        end
      end
      WRITE: begin
        state_d    = RESP;
        wb_valid_d = 1'b1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      load_q      <= 1'b0;
      byte_q      <= 1'b0;
      lane_q      <= 2'b00;
      bdata_q     <= 8'h0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      wb_valid_q  <= 1'b0;
      wb_write_q  <= 1'b0;
      wb_abort_q  <= 1'b0;
      wb_dest_q   <= 4'h0;
      wb_data_q   <= 32'h0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      byte_q      <= byte_d;
      lane_q      <= lane_d;
      bdata_q     <= bdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      wb_valid_q  <= wb_valid_d;
      wb_write_q  <= wb_write_d;
      wb_abort_q  <= wb_abort_d;
      wb_dest_q   <= wb_dest_d;
      wb_data_q   <= wb_data_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign mem_trans = ((state_q == READ) || (state_q == WRITE)) ? 2'b10 : 2'b00;
  assign mem_write = (state_q == WRITE);
  assign mem_size  = 1'b1;
  assign mem_prot  = PROT_DATA;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign wb_valid  = wb_valid_q;
  assign wb_write  = wb_write_q;
  assign wb_abort  = wb_abort_q;
  assign wb_dest   = wb_dest_q;
  assign wb_data   = wb_data_q;

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Load/store stage between instruction_execute and write_back.
- Takes one LDR/STR/LDRB/STRB request per handshake from execute. Drives the word-indexed memory bus (addr, wdata, rdata, abort, write, size, prot, trans) and returns one result per request to write-back.
- Byte stores use an internal read-modify-write, because the memory has no byte enables.
- Holds req_ready low while busy so upstream stalls.

Parameters:
MEM_WORDS, 8192, memory depth in 32-bit words; must be a power of 2.
PROT_DATA, 2'b01, constant value driven on mem_prot (data access, user mode).

Ports:
clk  in  1  clock
reset  in  1  reset
req_valid  in  1  execute presents a memory op
req_ready  out  1  high only in IDLE; transfer on req_valid&&req_ready at posedge
req_load  in  1  1=load, 0=store
req_byte  in  1  1=byte op, 0=word op
req_addr  in  32  byte address
req_wdata  in  32  store data; byte stores use [7:0]
req_dest  in  4  load destination register
wb_valid  out  1  one-cycle result pulse, one per accepted request
wb_write  out  1  with wb_valid: register write required (non-aborted load)
wb_dest  out  4  destination register
wb_data  out  32  load result
wb_abort  out  1  with wb_valid: access aborted
mem_addr  out  32  word index = req_addr>>2
mem_wdata  out  32  write data
mem_rdata  in  32  read data, valid the cycle after the read beat
mem_abort  in  1  abort, sampled with mem_rdata
mem_write  out  1  1=write beat
mem_size  out  1  tied 1 (word); byte handling is internal
mem_prot  out  2  PROT_DATA
mem_trans  out  2  2'b10 on an access beat, 2'b00 otherwise

Behaviour:
- Interface: one clock `clk`; reset is synchronous and active-high, port `reset`.
- States: IDLE, READ, RDATA, WRITE, RESP. On accept, latch load, byte, addr, wdata and dest.
- Bus outputs decode from state plus latched fields:
  - mem_trans=2'b10 only in READ or WRITE.
  - mem_write=1 only in WRITE.
  - mem_addr is the latched word index; it holds its last value outside beats.
- IDLE, on accept:
  - out-of-range (see Optional Feature) -> RESP with abort.
  - load or byte store -> READ.
  - word store -> WRITE.
- READ -> RDATA, unconditionally.
- RDATA: sample mem_rdata and mem_abort.
  - mem_abort=1 -> RESP with abort; no write beat follows.
  - load -> RESP with extracted data.
  - byte store -> WRITE with merged word.
- WRITE -> RESP.
- RESP -> IDLE. Registered wb_* outputs are valid in RESP only; wb_valid=1 for exactly one cycle.
- Latency, counted as edges from the accept edge to wb_valid high:
  - bounds abort: 1
  - word store: 2
  - load: 3
  - byte store: 4
  - req_ready is high again the cycle after RESP.
- Load extraction, little-endian, with lane = addr[1:0]:
  - byte load: word[8*lane+7:8*lane], zero-extended.
  - word load: word rotated right by 8*lane.
- Store merge:
  - byte store replaces lane bits with wdata[7:0] and keeps the other bits from the read word.
  - word store writes req_wdata unmodified at the aligned index; addr[1:0] is ignored.
- wb_write=1 only for non-aborted loads. On abort, wb_data=0 and wb_write=0.
- Stores return wb_valid with wb_write=0 and wb_dest = latched dest (don't-care).
- Reset values:
  - state IDLE; req_ready=1.
  - wb_valid, wb_write, wb_abort = 0; wb_dest=0; wb_data=0.
  - mem_trans=2'b00, mem_write=0, mem_addr=0, mem_wdata=0.
- Reset mid-operation: the next cycle is IDLE with no beat. A pending byte-store write is dropped, and no wb_valid is emitted for the killed request.
- req_valid while busy is ignored and not queued; upstream must hold it.

Optional Feature:
- Macro MEMORY_ACCESS_BOUNDS_CHECK_EN.
- Defined: word index >= MEM_WORDS gives IDLE -> RESP directly with wb_abort=1. No bus beat is issued; mem_trans stays 2'b00.
- Undefined: the word index is taken modulo MEM_WORDS (low bits), always goes to the bus, and only mem_abort can abort.

Test Plan:
1. memory[5]=0xDEADBEEF; load, word, addr 0x14, dest 3 -> one READ beat at mem_addr 5; wb_valid 3 edges after accept; wb_data 0xDEADBEEF, wb_dest 3, wb_write 1.
2. Same memory; load byte addr 0x16 -> wb_data 0x000000AD. Word load addr 0x15 -> wb_data 0xEFDEADBE.
3. memory[5]=0xDEADBEEF; store byte addr 0x15, wdata 0x12345677 -> one read beat then exactly one write beat; memory[5]=0xDEAD77EF; wb_valid 4 edges after accept, wb_write 0.
4. Word store addr 0x20, wdata 0xCAFEF00D -> single write beat at mem_addr 8, wb_valid 2 edges after accept. Back-to-back req_valid is accepted only when req_ready=1.
5. mem_abort forced high during RDATA of a byte store -> no write beat, wb_abort 1, wb_write 0, memory unchanged. With MEMORY_ACCESS_BOUNDS_CHECK_EN, a load at addr 0x8000 -> wb_abort 1 one edge after accept and mem_trans never 2'b10. Without the macro, the same request reads index 0.
6. reset asserted while in RDATA of a byte store -> next cycle mem_trans 2'b00, mem_write 0, req_ready 1, no wb_valid; memory unchanged.
